// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the target, the initiator and the bench VIP.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWr,
        StWrAck,
        StRd,
        StRdAck
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_if.sv
// I2C bus. The open-drain wired-AND with pull-up is modelled with pull-low enables:
// a released line (Z) reads back as 1.
interface i2c_if;
    logic scl;
    logic sda_m_pull;
    logic sda_t_pull;
    logic sda;

    assign sda = ~(sda_m_pull | sda_t_pull);

    modport target (input scl, input sda, output sda_t_pull);
    modport initiator (output scl, output sda_m_pull, input sda);
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer plus one edge register; flags bus edges, START and STOP.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;

    // Reset to the idle-bus level so leaving reset creates no false edges.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte-wide write delivery and read serving.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    i2c_if.target       i2c,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        tx_req,
    input  logic [7:0]  tx_data,
    output logic        busy,
    output logic        stop_det
);

    logic scl_rise;
    logic scl_fall;
    logic sda_s;
    logic bus_start;
    logic bus_stop;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rstn     (rstn),
        .scl      (i2c.scl),
        .sda      (i2c.sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start_det(bus_start),
        .stop_det (bus_stop)
    );

    i2c_tgt_state_t state_q;
    logic [7:0]     shreg_q;
    logic [3:0]     bit_cnt_q;
    logic           match_q;
    logic           rw_q;
    logic           sda_pull_q;

    assign i2c.sda_t_pull = sda_pull_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            match_q    <= 1'b0;
            rw_q       <= I2C_WRITE;
            sda_pull_q <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            stop_det <= 1'b0;

            if (bus_stop) begin
                state_q    <= StIdle;
                sda_pull_q <= 1'b0;
                bit_cnt_q  <= '0;
                busy       <= 1'b0;
                stop_det   <= 1'b1;
            end else if (bus_start) begin
                // busy is left alone until the new address is evaluated
                state_q    <= StAddr;
                sda_pull_q <= 1'b0;
                bit_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        sda_pull_q <= 1'b0;
                    end

                    StAddr: begin
                        if (scl_rise) begin
                            shreg_q   <= {shreg_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rw_q <= sda_s;
                                if (shreg_q[6:0] == TARGET_ADDR) begin
                                    match_q <= 1'b1;
                                    busy    <= 1'b1;
                                    tx_req  <= (sda_s == I2C_READ);
                                end else begin
                                    match_q <= 1'b0;
                                end
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= '0;
                            if (match_q) begin
                                sda_pull_q <= 1'b1;
                                state_q    <= StAddrAck;
                            end else begin
                                sda_pull_q <= 1'b0;
                                busy       <= 1'b0;
                                state_q    <= StIdle;
                            end
                        end
                    end

                    StAddrAck: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (rw_q == I2C_WRITE) begin
                                sda_pull_q <= 1'b0;
                                state_q    <= StWr;
                            end else begin
                                shreg_q    <= tx_data;
                                sda_pull_q <= ~tx_data[7];
                                state_q    <= StRd;
                            end
                        end
                    end

                    StWr: begin
                        if (scl_rise) begin
                            shreg_q   <= {shreg_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rx_data  <= {shreg_q[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q  <= '0;
                            sda_pull_q <= 1'b1;
                            state_q    <= StWrAck;
                        end
                    end

                    StWrAck: begin
                        if (scl_fall) begin
                            sda_pull_q <= 1'b0;
                            state_q    <= StWr;
                        end
                    end

                    StRd: begin
                        // bit_cnt_q counts bits already driven after the MSB
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q  <= '0;
                                sda_pull_q <= 1'b0;
                                state_q    <= StRdAck;
                            end else begin
                                shreg_q    <= {shreg_q[6:0], 1'b0};
                                sda_pull_q <= ~shreg_q[6];
                                bit_cnt_q  <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                tx_req <= 1'b1;
                            end else begin
                                sda_pull_q <= 1'b0;
                                busy       <= 1'b0;
                                state_q    <= StIdle;
                            end
                        end else if (scl_fall) begin
                            // only reachable after an ACK: NACK already left this state
                            shreg_q    <= tx_data;
                            sda_pull_q <= ~tx_data[7];
                            bit_cnt_q  <= '0;
                            state_q    <= StRd;
                        end
                    end

                    default: begin
                        sda_pull_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder for the bus carried by `i2c_if`. It is the far end of the `i2c_ctrl` initiator.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs, then either delivers written bytes or serves read bytes to local logic through a byte-wide handshake.
- Drives SDA open-drain only: low or Z. Never drives SCL; no clock stretching.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address the block responds to.
- SYNC_STAGES, 2, synchronizer flops on SCL/SDA. Minimum 2.

Ports:
- clk  input  1  system clock. Must be at least 8x the SCL frequency.
- rstn  input  1  reset, synchronous, active-low.
- i2c  interface  i2c_if  bus. SCL is sampled only. SDA is sampled and pulled low or released (Z).
- rx_data  output  8  last data byte written by the initiator.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- tx_req  output  1  one-clk pulse requesting the next read byte.
- tx_data  input  8  read byte. Must be valid within 2 clk of tx_req.
- busy  output  1  high from an address-matched START until STOP or NACK-release.
- stop_det  output  1  one-clk pulse on any bus STOP.

Behaviour:
- Reset (rstn=0 at a clk edge) sets: state IDLE, SDA released (Z), rx_data=0, rx_valid=0, tx_req=0, busy=0, stop_det=0. This also applies mid-transfer; SDA is released on the same edge.
- Front end:
  - SYNC_STAGES flops on SCL and SDA, then one edge-detect register.
  - Detection latency is SYNC_STAGES+1 clk from a pin change.
  - scl_rise, scl_fall: SCL edges.
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - START and STOP take priority over bit events in the same cycle.
- Data bits are sampled on scl_rise. SDA drive changes only on scl_fall, within 1 clk of detection.
- States: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK.
  - IDLE: on START -> ADDR with bit counter cleared.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W).
    - On the 8th scl_rise, if address == TARGET_ADDR: set busy. If R/W=1, pulse tx_req.
    - On the next scl_fall: if matched, pull SDA low -> ADDR_ACK. If not matched, go IDLE with SDA released.
  - ADDR_ACK: on scl_fall, release SDA.
    - R/W=0 -> WR.
    - R/W=1 -> RD: load tx_data into the shift register and drive its MSB.
  - WR: shift 8 bits. On the 8th scl_rise, update rx_data and pulse rx_valid. On scl_fall, pull SDA low -> WR_ACK.
  - WR_ACK: on scl_fall, release SDA -> WR. The target always ACKs written bytes.
  - RD: on each scl_fall, drive the next bit (0 = pull low, 1 = release). After the 8th bit's scl_fall, release SDA -> RD_ACK.
  - RD_ACK: sample initiator ACK on scl_rise.
    - ACK (SDA low): pulse tx_req; on scl_fall, load tx_data and drive its MSB -> RD.
    - NACK: go IDLE, release SDA, clear busy.
- Repeated START in any state: -> ADDR, release SDA, busy unchanged until address re-evaluation.
- STOP in any state: -> IDLE, release SDA, clear busy, pulse stop_det.
- General-call address (0x00) is not matched unless TARGET_ADDR=0.
- A partial byte cut off by START or STOP is discarded, with no rx_valid.
- SDA is never pulled low while in IDLE.

Decomposition:
- Shared package `i2c_pkg` holds:
  - state enum `i2c_tgt_state_t`
  - constants `I2C_ACK`=0, `I2C_NACK`=1, `I2C_WRITE`=0, `I2C_READ`=1
  - `I2C_ADDR_W`=7
  - this package is shared with `i2c_ctrl` and the VIP.
- One sub-module, `i2c_line_sync`:
  - synchronizer plus edge register
  - outputs scl_rise, scl_fall, sda_s, start_det, stop_det
  - reusable by `i2c_ctrl` for arbitration checks.

Test Plan:
- Write: bench master (`I2CVip`) runs xmit_write(addr 0x50, {0xAF, 0x55}).
  - Required: ACK on the address and on both bytes.
  - Required: rx_valid pulses twice, with rx_data 0xAF then 0x55.
  - Required: stop_det pulses once; busy returns to 0.
- Address mismatch: xmit_write(addr 0x51, {0x12}).
  - Required: the master sees NACK; SDA is never pulled low; no rx_valid; busy stays 0.
- Read: xmit_read(addr 0x50, 2 bytes) with tx_data returning 0x3C then 0xC3 on successive tx_req.
  - Required: the master receives 0x3C, 0xC3.
  - Required: after the final NACK the target releases SDA and returns to IDLE.
- Repeated START: write 0x50 {0x01}, then repeated START, then read 0x50 with 1 byte (tx_data=0x9A).
  - Required: rx_data=0x01 and the read returns 0x9A, with no STOP between them.
- Abort: rstn asserted while the target drives an ACK low.
  - Required: SDA is Z on the next clk and all outputs are at reset values.
  - Required: a following clean write 0x50 {0x77} gives rx_data=0x77.
- STOP mid-byte: STOP after 4 data bits of a write.
  - Required: no rx_valid, stop_det pulses once, state is IDLE, and the next transaction succeeds.
